beep_pattern_sched: RTL and testbench
=====================================

// Module: beep_pattern_sched
// PURPOSE
//  Shares the single buzzer between NUM_REQ debounced key requesters. A falling edge on key i
//  queues a request; the scheduler arbitrates among pending requests and plays a pattern of
//  i+1 beep pulses for the winner. It sits between the key debouncers and the buzzer pin.
// PARAMETERS
//  NUM_REQ  2   number of requesters (1..4); requester i plays i+1 pulses
//  ON_CYC   50_000_000/10  beep-on length per pulse, sys_clk cycles (>=1)
//  OFF_CYC  50_000_000/10  silent time between pulses of one pattern (>=1)
//  GAP_CYC  50_000_000/4   silent guard time after a pattern before next grant (>=1)
// PORTS
//  sys_clk     in   1        clock
//  sys_rst_n   in   1        reset, asynchronous, active-low
//  key_filter  in   NUM_REQ  debounced keys, active-low, idle high
//  beep        out  1        buzzer drive, active-low (0 = sounding, 1 = silent)
//  busy        out  1        1 while state != IDLE
//  grant       out  NUM_REQ  one-hot requester being served; 0 in IDLE
//  pending     out  NUM_REQ  queued, not-yet-served requests
// BEHAVIOUR
//  Reset: key_d0 all 1s, pending=0, grant=0, beep=1, busy=0, state=IDLE, counters=0.
//  Edge detect: fall[i] = ~key_filter[i] & key_d0[i]; key_d0 <= key_filter every cycle.
//  pending[i]: set by fall[i]; cleared when granted; set wins if both in same cycle.
//   An edge while pending[i] already 1 is absorbed (no counting, one pattern per pending).
//  FSM (all outputs registered):
//   IDLE: if pending!=0 -> pick winner w, grant=onehot(w), pending[w] cleared,
//         pulse_left=w+1, cnt=0, beep<=0, -> ON.
//   ON:   beep=0; cnt counts 0..ON_CYC-1; at ON_CYC-1: pulse_left-=1, cnt=0;
//         if pulse_left==1 -> GAP, else -> OFF; beep<=1 on exit.
//   OFF:  beep=1 for OFF_CYC cycles, then beep<=0, -> ON.
//   GAP:  beep=1 for GAP_CYC cycles; at end grant<=0, -> IDLE.
//  Latency: fall[i] in cycle N -> pending[i]=1 at N+1 -> beep=0, grant valid at N+2 (if IDLE).
//  Pattern for requester i: exactly i+1 low pulses of ON_CYC, separated by OFF_CYC highs,
//   total busy = (i+1)*ON_CYC + i*OFF_CYC + GAP_CYC cycles.
//  Requests arriving while busy are queued, never pre-empt the active pattern.
//  Counter width $clog2(max(ON_CYC,OFF_CYC,GAP_CYC)+1); compare with equality, no wrap.
//  Simultaneous falls on several keys: all pending bits set; served one per pattern.
//  Async reset mid-pattern: immediate return to reset values, pattern and queue dropped.
//  Keys held low never retrigger; a new press requires release (high) then fall.
// CONFIGURATION
//  BEEP_SCHED_RR_EN defined: round-robin; rr_ptr (reset 0) = index after last winner,
//   winner = first pending at or after rr_ptr, wrapping modulo NUM_REQ.
//  BEEP_SCHED_RR_EN undefined: fixed priority, lowest pending index wins; no rr_ptr.
// TESTING (NUM_REQ=2, ON_CYC=4, OFF_CYC=3, GAP_CYC=5)
//  1 Reset release, keys high -> beep=1, busy=0, grant=00, pending=00 indefinitely.
//  2 Fall key0 at cycle N -> pending=01 at N+1; beep low N+2..N+5, grant=01,
//    busy through N+10, grant=00 and busy=0 at N+11.
//  3 Fall key1 -> beep low 4, high 3, low 4, high 5; grant=10 for 16 cycles.
//  4 Fall key0 and key1 same cycle -> fixed: key0 pattern then key1; RR (ptr=0) same,
//    then repeat both -> RR gives key0, key1 again; fixed gives key0 first each time.
//  5 Fall key1 twice during its own pattern -> exactly one extra 2-pulse pattern queued.
//  6 Assert sys_rst_n=0 during second ON pulse -> beep=1, grant=0, pending=0 same cycle;
//    after release, no beep until a new falling edge.

Source files
------------

// File: rtl/beep_pattern_sched.sv
`default_nettype none
// ============================================================================
// Module   : beep_pattern_sched
// Summary  : Shares one active-low buzzer among NUM_REQ debounced keys; a key
//            press queues a request and requester i plays i+1 beep pulses.
//            Define BEEP_SCHED_RR_EN for round-robin arbitration; otherwise
//            the lowest pending index wins.
// Revision : 1.0 - initial release
// ============================================================================
module beep_pattern_sched #(
  parameter int NUM_REQ = 2,
  parameter int ON_CYC  = 50_000_000/10,
  parameter int OFF_CYC = 50_000_000/10,
  parameter int GAP_CYC = 50_000_000/4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [NUM_REQ-1:0] key_filter,
  output logic               beep,
  output logic               busy,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] pending
);

  localparam int c_on_off_max = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int c_cnt_max    = (c_on_off_max > GAP_CYC) ? c_on_off_max : GAP_CYC;
  localparam int c_cnt_w      = $clog2(c_cnt_max + 1);
  localparam int c_idx_w      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [c_cnt_w-1:0] c_on_last  = c_cnt_w'(ON_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_off_last = c_cnt_w'(OFF_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last = c_cnt_w'(GAP_CYC - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_on   = 2'd1;
  localparam logic [1:0] c_st_off  = 2'd2;
  localparam logic [1:0] c_st_gap  = 2'd3;

  logic [NUM_REQ-1:0] r_key_d0;
  logic [NUM_REQ-1:0] r_pending;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_beep;
  logic               r_busy;
  logic [1:0]         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2:0]         r_pulse_left;

  logic [NUM_REQ-1:0] w_fall;
  logic [NUM_REQ-1:0] w_win_onehot;
  logic [NUM_REQ-1:0] w_clear;
  logic [c_idx_w-1:0] w_win_idx;
  logic               w_found;
  logic               w_take;

  assign w_fall = ~key_filter & r_key_d0;
  assign w_take = (r_state == c_st_idle) && w_found;
  assign w_clear = w_take ? w_win_onehot : '0;

`ifdef BEEP_SCHED_RR_EN
  logic [c_idx_w-1:0] r_rr_ptr;
  logic [c_idx_w:0]   w_probe;

  // Search starts at the slot after the previous winner and wraps once.
  always_comb begin
    w_win_idx = '0;
    w_found   = 1'b0;
    w_probe   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_probe = {1'b0, r_rr_ptr} + (c_idx_w+1)'(k);
      if (w_probe >= (c_idx_w+1)'(NUM_REQ)) begin
        w_probe = w_probe - (c_idx_w+1)'(NUM_REQ);
      end
      if (!w_found && r_pending[w_probe[c_idx_w-1:0]]) begin
        w_win_idx = w_probe[c_idx_w-1:0];
        w_found   = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_take) begin
      r_rr_ptr <= (int'(w_win_idx) == NUM_REQ - 1) ? '0 : w_win_idx + c_idx_w'(1);
    end
  end
`else
  always_comb begin
    w_win_idx = '0;
    w_found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && r_pending[k]) begin
        w_win_idx = c_idx_w'(k);
        w_found   = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    w_win_onehot            = '0;
    w_win_onehot[w_win_idx] = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_key_d0     <= '1;
      r_pending    <= '0;
      r_grant      <= '0;
      r_beep       <= 1'b1;
      r_busy       <= 1'b0;
      r_state      <= c_st_idle;
      r_cnt        <= '0;
      r_pulse_left <= '0;
    end else begin
      r_key_d0  <= key_filter;
      // A new fall outranks the clear so a same-cycle press is never lost.
      r_pending <= (r_pending & ~w_clear) | w_fall;
      case (r_state)
        c_st_idle: begin
          if (w_found) begin
            r_grant      <= w_win_onehot;
            r_pulse_left <= 3'(w_win_idx) + 3'd1;
            r_cnt        <= '0;
            r_beep       <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= c_st_on;
          end
        end
        c_st_on: begin
          if (r_cnt == c_on_last) begin
            r_cnt        <= '0;
            r_pulse_left <= r_pulse_left - 3'd1;
            r_beep       <= 1'b1;
            r_state      <= (r_pulse_left == 3'd1) ? c_st_gap : c_st_off;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        c_st_off: begin
          if (r_cnt == c_off_last) begin
            r_cnt   <= '0;
            r_beep  <= 1'b0;
            r_state <= c_st_on;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        c_st_gap: begin
          if (r_cnt == c_gap_last) begin
            r_cnt   <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= c_st_idle;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign beep    = r_beep;
  assign busy    = r_busy;
  assign grant   = r_grant;
  assign pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_beep_pattern_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_beep_pattern_sched
// Summary  : Randomized and directed key stimulus for beep_pattern_sched with a
//            timeline reference model feeding a grant scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_beep_pattern_sched;

  localparam int N   = 2;
  localparam int ON  = 4;
  localparam int OFF = 3;
  localparam int GAP = 5;

  logic         sys_clk   = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic [N-1:0] key_filter = '1;
  logic         beep;
  logic         busy;
  logic [N-1:0] grant;
  logic [N-1:0] pending;

  beep_pattern_sched #(
    .NUM_REQ (N),
    .ON_CYC  (ON),
    .OFF_CYC (OFF),
    .GAP_CYC (GAP)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_filter (key_filter),
    .beep       (beep),
    .busy       (busy),
    .grant      (grant),
    .pending    (pending)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int who;
    int start;
  } exp_t;

  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  exp_t         exp_q[$];
  exp_t         e;
  logic [N-1:0] mpend       = '0;
  logic [N-1:0] mkey_prev   = '1;
  logic [N-1:0] exp_pending = '0;
  logic [N-1:0] falls;
  int           idle_at = 0;
  int           rr      = 0;
  int           w;
  bit           active  = 1'b0;
  int           aw;
  int           at;
  int           alen;

  function automatic int pattern_len(int who);
    return (who + 1) * ON + who * OFF + GAP;
  endfunction

  // Offset t inside requester who's pattern: pulses then the silent guard.
  function automatic logic exp_beep(int t, int who);
    if (t < (who + 1) * ON + who * OFF) return ((t % (ON + OFF)) < ON) ? 1'b0 : 1'b1;
    return 1'b1;
  endfunction

  function automatic logic [N-1:0] onehot(int who);
    logic [N-1:0] v;
    v      = '0;
    v[who] = 1'b1;
    return v;
  endfunction

  function automatic int pick(logic [N-1:0] p, int ptr);
    int first;
`ifdef BEEP_SCHED_RR_EN
    first = ptr;
`else
    first = 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (p[(first + k) % N]) return (first + k) % N;
    end
    return 0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: pending set plus the cycle at which the buzzer frees up.
  initial forever begin
    @(posedge sys_clk);
    if (!sys_rst_n) begin
      mpend       = '0;
      mkey_prev   = '1;
      exp_pending = '0;
      idle_at     = 0;
      rr          = 0;
      exp_q.delete();
    end else begin
      falls = ~key_filter & mkey_prev;
      if (cyc >= idle_at && mpend != '0) begin
        w = pick(mpend, rr);
        e.who   = w;
        e.start = cyc + 1;
        exp_q.push_back(e);
        idle_at  = cyc + 1 + pattern_len(w);
        mpend[w] = 1'b0;
        rr       = (w + 1) % N;
      end
      mpend       = mpend | falls;
      mkey_prev   = key_filter;
      exp_pending = mpend;
    end
    cyc++;
  end

  // Monitor: pops an expectation whenever the DUT raises a grant.
  initial forever begin
    @(negedge sys_clk);
    if (!sys_rst_n) begin
      active = 1'b0;
      check("rst_beep", 32'(beep), 32'd1);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
    end else begin
      check("pending", 32'(pending), 32'(exp_pending));
      if (!active && grant != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(grant), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("grant_start_cycle", 32'(cyc), 32'(e.start));
          active = 1'b1;
          aw     = e.who;
          at     = 0;
          alen   = pattern_len(e.who);
        end
      end else if (!active && exp_q.size() > 0 && exp_q[0].start < cyc) begin
        e = exp_q.pop_front();
        check("missing_grant", 32'(grant), 32'(onehot(e.who)));
      end
      if (active) begin
        check("pat_beep", 32'(beep), 32'(exp_beep(at, aw)));
        check("pat_grant", 32'(grant), 32'(onehot(aw)));
        check("pat_busy", 32'(busy), 32'd1);
        at++;
        if (at == alen) active = 1'b0;
      end else begin
        check("idle_beep", 32'(beep), 32'd1);
        check("idle_grant", 32'(grant), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
      end
    end
  end

  task automatic press(logic [N-1:0] mask, int hold);
    @(posedge sys_clk);
    #1 key_filter = key_filter & ~mask;
    repeat (hold) @(posedge sys_clk);
    #1 key_filter = key_filter | mask;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(cyc >= idle_at && mpend == '0 && exp_q.size() == 0 && !active) && n < 400) begin
      @(posedge sys_clk);
      n++;
    end
    total++;
    if (n >= 400) begin
      bad++;
      $display("FAIL drain_timeout: got busy after %0d cycles expected idle", n);
    end
    repeat (2) @(posedge sys_clk);
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;

    // Idle after reset with keys high.
    repeat (20) @(posedge sys_clk);

    press(2'b01, 2);
    wait_idle();
    press(2'b10, 3);
    wait_idle();

    // Simultaneous presses, twice, to exercise arbitration order.
    press(2'b11, 2);
    wait_idle();
    press(2'b11, 2);
    wait_idle();

    // Re-press key1 twice during its own pattern: one extra pattern only.
    press(2'b10, 1);
    repeat (3) @(posedge sys_clk);
    press(2'b10, 1);
    repeat (2) @(posedge sys_clk);
    press(2'b10, 1);
    wait_idle();

    // Held key never retriggers.
    press(2'b01, 40);
    wait_idle();

    // Asynchronous reset during the second ON pulse of key1's pattern.
    press(2'b10, 1);
    repeat (8) @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1;
    check("async_rst_beep", 32'(beep), 32'd1);
    check("async_rst_grant", 32'(grant), 32'd0);
    check("async_rst_pending", 32'(pending), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;
    repeat (25) @(posedge sys_clk);

    // Randomized key activity.
    for (int c = 0; c < 2500; c++) begin
      @(posedge sys_clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 29) == 0) key_filter[k] = ~key_filter[k];
      end
    end
    @(posedge sys_clk);
    #1 key_filter = '1;
    wait_idle();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
